// File: rtl/tx_medida_pkg.sv
// Shared definitions for the BCD-to-ASCII frame serialiser.
// Optional feature macro: TX_CRLF_EN (appends CR, LF after the terminator).
package tx_medida_pkg;

  typedef enum logic [3:0] {
    INICIAL   = 4'h0,
    PREPARA   = 4'h1,
    TRANSMITE = 4'h2,
    ESPERA    = 4'h3,
    PROXIMO   = 4'h4,
    FINAL     = 4'h5,
    ERRO      = 4'hF
  } estado_t;

  localparam logic [6:0] ASCII_ZERO     = 7'h30;
  localparam logic [6:0] ASCII_INVALIDO = 7'h3F;
  localparam logic [6:0] ASCII_CR       = 7'h0D;
  localparam logic [6:0] ASCII_LF       = 7'h0A;

`ifdef TX_CRLF_EN
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd5;
`else
  localparam int IDX_W = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;
`endif

  // Non-decimal nibbles are shown as '?' so a corrupt reading is visible on the terminal
  function automatic logic [6:0] bcd_to_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (ASCII_ZERO | {3'b000, d}) : ASCII_INVALIDO;
  endfunction

endpackage

// File: rtl/tx_medida_watchdog.sv
// Up-counter guarding the wait for the UART completion pulse.
// Cleared on entry to the wait state, counts while enabled, flags the last allowed cycle.
module tx_medida_watchdog
  #(parameter int LIMITE = 50000,
    localparam int W = $clog2(LIMITE + 1))
  (input  logic clock,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o);

  logic [W-1:0] cnt_q;

  // tc marks the LIMITE-th enabled cycle, so the owner leaves after exactly LIMITE cycles
  assign tc_o = en_i && (cnt_q == W'(LIMITE - 1));

  // Count enabled cycles; hold at the limit until cleared
  always_ff @(posedge clock) begin
    if (!reset)                cnt_q <= '0;
    else if (clr_i)            cnt_q <= '0;
    else if (en_i && !tc_o)    cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/tx_medida_ascii.sv
// Serialises a latched 3-digit BCD distance into ASCII characters, one per UART handshake:
// hundreds, tens, units, terminator (plus CR, LF when TX_CRLF_EN is defined).
// A watchdog aborts the frame if the transmitter never reports completion.
module tx_medida_ascii
  import tx_medida_pkg::*;
  #(parameter logic [6:0] TERMINADOR = 7'h23,
    parameter int         TIMEOUT    = 50000)
  (input  logic        clock,
   input  logic        reset,
   input  logic        enviar,
   input  logic [11:0] medida,
   input  logic        tx_pronto,
   output logic        tx_partida,
   output logic [6:0]  tx_dados,
   output logic        ocupado,
   output logic        pronto,
   output logic        erro,
   output logic [3:0]  db_estado);

  estado_t          estado_q;
  logic [11:0]      medida_q;
  logic [IDX_W-1:0] idx_q;
  logic             tx_partida_q, ocupado_q, pronto_q, erro_q;
  logic [6:0]       tx_dados_q;
  logic [6:0]       char_d;
  logic             wd_tc;

  assign tx_partida = tx_partida_q;
  assign tx_dados   = tx_dados_q;
  assign ocupado    = ocupado_q;
  assign pronto     = pronto_q;
  assign erro       = erro_q;
  assign db_estado  = estado_q;

  // Watchdog restarts as we enter ESPERA and only runs while there
  tx_medida_watchdog #(.LIMITE(TIMEOUT)) u_wd (
    .clock (clock),
    .reset (reset),
    .clr_i (estado_q == TRANSMITE),
    .en_i  (estado_q == ESPERA),
    .tc_o  (wd_tc)
  );

  // Character for the current frame position, taken from the latched reading
  always_comb begin
    char_d = ASCII_INVALIDO;
    case (idx_q)
      IDX_W'(0): char_d = bcd_to_ascii(medida_q[11:8]);
      IDX_W'(1): char_d = bcd_to_ascii(medida_q[7:4]);
      IDX_W'(2): char_d = bcd_to_ascii(medida_q[3:0]);
      IDX_W'(3): char_d = TERMINADOR;
`ifdef TX_CRLF_EN
      IDX_W'(4): char_d = ASCII_CR;
      IDX_W'(5): char_d = ASCII_LF;
`endif
      default:   char_d = ASCII_INVALIDO;
    endcase
  end

  // Frame sequencer with registered outputs; partida/pronto default low so they pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q     <= INICIAL;
      medida_q     <= '0;
      idx_q        <= '0;
      tx_partida_q <= 1'b0;
      tx_dados_q   <= 7'h00;
      ocupado_q    <= 1'b0;
      pronto_q     <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      tx_partida_q <= 1'b0;
      pronto_q     <= 1'b0;
      case (estado_q)
        INICIAL, ERRO: begin
          if (enviar) begin
            medida_q  <= medida;
            idx_q     <= '0;
            erro_q    <= 1'b0;
            ocupado_q <= 1'b1;
            estado_q  <= PREPARA;
          end
        end
        PREPARA: begin
          tx_dados_q <= char_d;
          estado_q   <= TRANSMITE;
        end
        TRANSMITE: begin
          tx_partida_q <= 1'b1;
          estado_q     <= ESPERA;
        end
        ESPERA: begin
          // a completion arriving on the limit cycle still counts as success
          if (tx_pronto) begin
            estado_q <= PROXIMO;
          end else if (wd_tc) begin
            erro_q    <= 1'b1;
            ocupado_q <= 1'b0;
            estado_q  <= ERRO;
          end
        end
        PROXIMO: begin
          if (idx_q == LAST_IDX) begin
            pronto_q <= 1'b1;
            estado_q <= FINAL;
          end else begin
            idx_q    <= idx_q + IDX_W'(1);
            estado_q <= PREPARA;
          end
        end
        FINAL: begin
          ocupado_q <= 1'b0;
          estado_q  <= INICIAL;
        end
        default: begin
          ocupado_q <= 1'b0;
          estado_q  <= INICIAL;
        end
      endcase
    end
  end

endmodule
